// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares the single 8-bit / 21-bit-address external SRAM port between the
//   HPS download path, the video fetch engine and the CPU bus. Each access is
//   a fixed IDLE -> ACCESS (ACCESS_CYCLES clocks) -> DONE sequence; the owner
//   receives a one-cycle acknowledge in DONE.
//
//   Ports
//     clk_sys, reset_n          clock, synchronous active-low reset
//     dl_wr/dl_addr/dl_data     download write strobe, address, byte
//     dl_wait                   back-pressure to the download source
//     vid_req/vid_addr          video read request (level) and address
//     vid_ack/vid_data          one-cycle ack, read data
//     cpu_req/cpu_we/cpu_addr/cpu_wdata   CPU request (level), direction, addr, data
//     cpu_ack/cpu_rdata         one-cycle ack, read data
//     mem_addr/mem_wdata/mem_oe/mem_we_n/mem_rdata   SRAM pins
//     owner                     0 none, 1 download, 2 video, 3 CPU
//
//   Optional: define SRAM_ARB_FAIR_EN to let the CPU in after FAIR_MAX
//   consecutive video grants made while it was waiting.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | bus free, arbitrate download > video > CPU
//   ST_ACCESS | address/data/strobe held, cnt_q counts down to zero
//   ST_DONE   | strobes released, address held, owner's ack pulses
module sram_arbiter #(
   parameter int ACCESS_CYCLES = 2,
   parameter int FAIR_MAX      = 4
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        dl_wr,
   input  logic [20:0] dl_addr,
   input  logic [7:0]  dl_data,
   output logic        dl_wait,
   input  logic        vid_req,
   input  logic [20:0] vid_addr,
   output logic        vid_ack,
   output logic [7:0]  vid_data,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [20:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_ack,
   output logic [7:0]  cpu_rdata,
   output logic [20:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_oe,
   output logic        mem_we_n,
   input  logic [7:0]  mem_rdata,
   output logic [1:0]  owner
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_DONE = 2'd2} state_t;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_DL   = 2'd1;
   localparam logic [1:0] OWN_VID  = 2'd2;
   localparam logic [1:0] OWN_CPU  = 2'd3;
   localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

   generate
      if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_access_cycles
         $error("ACCESS_CYCLES must be 1..15");
      end
      if (FAIR_MAX < 1 || FAIR_MAX > 7) begin : g_bad_fair_max
         $error("FAIR_MAX must be 1..7");
      end
   endgenerate

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        dl_pend_q, dl_pend_d;
   logic [20:0] dl_addr_q, dl_addr_d;
   logic [7:0]  dl_data_q, dl_data_d;
   logic [20:0] mem_addr_q, mem_addr_d;
   logic [7:0]  mem_wdata_q, mem_wdata_d;
   logic        mem_oe_q, mem_oe_d;
   logic        mem_we_n_q, mem_we_n_d;
   logic [1:0]  owner_q, owner_d;
   logic        vid_ack_q, vid_ack_d;
   logic        cpu_ack_q, cpu_ack_d;
   logic [7:0]  vid_data_q, vid_data_d;
   logic [7:0]  cpu_rdata_q, cpu_rdata_d;
   logic        cpu_first;

`ifdef SRAM_ARB_FAIR_EN
   logic [2:0]  fair_q, fair_d;
   assign cpu_first = cpu_req && (fair_q >= 3'(FAIR_MAX));
`else
   assign cpu_first = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dl_pend_d   = dl_pend_q;
      dl_addr_d   = dl_addr_q;
      dl_data_d   = dl_data_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_oe_d    = mem_oe_q;
      mem_we_n_d  = mem_we_n_q;
      owner_d     = owner_q;
      vid_ack_d   = 1'b0;
      cpu_ack_d   = 1'b0;
      vid_data_d  = vid_data_q;
      cpu_rdata_d = cpu_rdata_q;
`ifdef SRAM_ARB_FAIR_EN
      fair_d      = cpu_req ? fair_q : 3'd0;
`endif

      // A strobe while a write is already pending is dropped, latches kept.
      if (dl_wr && !dl_pend_q) begin
         dl_pend_d = 1'b1;
         dl_addr_d = dl_addr;
         dl_data_d = dl_data;
      end

      case (state_q)
         ST_IDLE: begin
            // dl_wr is looked at directly so a strobe wins in its own cycle.
            if (dl_pend_q || dl_wr) begin
               state_d     = ST_ACCESS;
               cnt_d       = CNT_LOAD;
               owner_d     = OWN_DL;
               mem_addr_d  = dl_pend_q ? dl_addr_q : dl_addr;
               mem_wdata_d = dl_pend_q ? dl_data_q : dl_data;
               mem_oe_d    = 1'b1;
               mem_we_n_d  = 1'b0;
            end else if (cpu_first || (cpu_req && !vid_req)) begin
               state_d     = ST_ACCESS;
               cnt_d       = CNT_LOAD;
               owner_d     = OWN_CPU;
               mem_addr_d  = cpu_addr;
               mem_wdata_d = cpu_wdata;
               mem_oe_d    = cpu_we;
               mem_we_n_d  = !cpu_we;
`ifdef SRAM_ARB_FAIR_EN
               fair_d      = 3'd0;
`endif
            end else if (vid_req) begin
               state_d     = ST_ACCESS;
               cnt_d       = CNT_LOAD;
               owner_d     = OWN_VID;
               mem_addr_d  = vid_addr;
               mem_wdata_d = 8'd0;
               mem_oe_d    = 1'b0;
               mem_we_n_d  = 1'b1;
`ifdef SRAM_ARB_FAIR_EN
               if (cpu_req) fair_d = fair_q + 3'd1;
`endif
            end
         end
         ST_ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d    = ST_DONE;
               mem_oe_d   = 1'b0;
               mem_we_n_d = 1'b1;
               if (owner_q == OWN_VID) begin
                  vid_ack_d  = 1'b1;
                  vid_data_d = mem_rdata;
               end
               if (owner_q == OWN_CPU) begin
                  cpu_ack_d = 1'b1;
                  if (mem_we_n_q) cpu_rdata_d = mem_rdata;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
            if (owner_q == OWN_DL) dl_pend_d = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         dl_pend_q   <= 1'b0;
         dl_addr_q   <= 21'd0;
         dl_data_q   <= 8'd0;
         mem_addr_q  <= 21'd0;
         mem_wdata_q <= 8'd0;
         mem_oe_q    <= 1'b0;
         mem_we_n_q  <= 1'b1;
         owner_q     <= OWN_NONE;
         vid_ack_q   <= 1'b0;
         cpu_ack_q   <= 1'b0;
         vid_data_q  <= 8'd0;
         cpu_rdata_q <= 8'd0;
`ifdef SRAM_ARB_FAIR_EN
         fair_q      <= 3'd0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dl_pend_q   <= dl_pend_d;
         dl_addr_q   <= dl_addr_d;
         dl_data_q   <= dl_data_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_oe_q    <= mem_oe_d;
         mem_we_n_q  <= mem_we_n_d;
         owner_q     <= owner_d;
         vid_ack_q   <= vid_ack_d;
         cpu_ack_q   <= cpu_ack_d;
         vid_data_q  <= vid_data_d;
         cpu_rdata_q <= cpu_rdata_d;
`ifdef SRAM_ARB_FAIR_EN
         fair_q      <= fair_d;
`endif
      end
   end

   assign dl_wait   = dl_pend_q | dl_wr;
   assign vid_ack   = vid_ack_q;
   assign vid_data  = vid_data_q;
   assign cpu_ack   = cpu_ack_q;
   assign cpu_rdata = cpu_rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_oe    = mem_oe_q;
   assign mem_we_n  = mem_we_n_q;
   assign owner     = owner_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios on an ACCESS_CYCLES=2 instance,
// a single-cycle-access instance for the boundary case, and a randomized run
// checked against a schedule-level reference model.
module tb_sram_arbiter;

   localparam int AC   = 2;
   localparam int FMAX = 4;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        dl_wr;
   logic [20:0] dl_addr;
   logic [7:0]  dl_data;
   logic        vid_req;
   logic [20:0] vid_addr;
   logic        cpu_req;
   logic        cpu_we;
   logic [20:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic [7:0]  mem_rdata;

   logic        dl_wait, vid_ack, cpu_ack, mem_oe, mem_we_n;
   logic [7:0]  vid_data, cpu_rdata, mem_wdata;
   logic [20:0] mem_addr;
   logic [1:0]  owner;

   logic        b_dl_wait, b_vid_ack, b_cpu_ack, b_mem_oe, b_mem_we_n;
   logic [7:0]  b_vid_data, b_cpu_rdata, b_mem_wdata;
   logic [20:0] b_mem_addr;
   logic [1:0]  b_owner;

   int total = 0;
   int bad   = 0;

   always #5 clk_sys = ~clk_sys;

   sram_arbiter #(.ACCESS_CYCLES(AC), .FAIR_MAX(FMAX)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .dl_wait(dl_wait),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_oe(mem_oe), .mem_we_n(mem_we_n),
      .mem_rdata(mem_rdata), .owner(owner)
   );

   sram_arbiter #(.ACCESS_CYCLES(1), .FAIR_MAX(FMAX)) dut_b (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .dl_wait(b_dl_wait),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(b_vid_ack), .vid_data(b_vid_data),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
      .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_oe(b_mem_oe), .mem_we_n(b_mem_we_n),
      .mem_rdata(mem_rdata), .owner(b_owner)
   );

   task automatic tick();
      @(negedge clk_sys);
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
      vid_req = 1'b0; vid_addr = '0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      mem_rdata = '0;
      repeat (2) tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      int acks;
      apply_reset();
      total++;
      if ({owner, mem_we_n, mem_oe, mem_addr, mem_wdata, vid_ack, cpu_ack, vid_data, cpu_rdata, dl_wait}
          !== {2'd0, 1'b1, 1'b0, 21'd0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0}) begin
         bad++;
         $display("FAIL reset_state: got owner=%0d we_n=%0b oe=%0b addr=%0h wdata=%0h acks=%0b%0b data=%0h/%0h wait=%0b",
                  owner, mem_we_n, mem_oe, mem_addr, mem_wdata, vid_ack, cpu_ack, vid_data, cpu_rdata, dl_wait);
      end
      tick();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 21'h00010; cpu_wdata = 8'h5A;
      tick();
      total++;
      if ({owner, mem_we_n, mem_oe, mem_addr, mem_wdata} !== {2'd3, 1'b0, 1'b1, 21'h00010, 8'h5A}) begin
         bad++;
         $display("FAIL reset_write_grant: got owner=%0d we_n=%0b oe=%0b addr=%0h wdata=%0h want 3 0 1 10 5a",
                  owner, mem_we_n, mem_oe, mem_addr, mem_wdata);
      end
      reset_n = 1'b0; cpu_req = 1'b0;
      tick();
      total++;
      if ({owner, mem_we_n, mem_oe} !== {2'd0, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL reset_mid_write: got owner=%0d we_n=%0b oe=%0b want 0 1 0", owner, mem_we_n, mem_oe);
      end
      reset_n = 1'b1;
      acks = cpu_ack ? 1 : 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (cpu_ack) acks++;
      end
      total++;
      if (acks != 0) begin
         bad++;
         $display("FAIL reset_no_ack: got %0d cpu_ack pulses want 0", acks);
      end
   endtask

   task automatic test_cpu_read();
      apply_reset();
      tick();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 21'h1FFFFF; mem_rdata = 8'hC3;
      tick();
      total++;
      if ({mem_addr, owner, mem_we_n, mem_oe, cpu_ack} !== {21'h1FFFFF, 2'd3, 1'b1, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL cpu_read_t1: got addr=%0h owner=%0d we_n=%0b oe=%0b ack=%0b want 1fffff 3 1 0 0",
                  mem_addr, owner, mem_we_n, mem_oe, cpu_ack);
      end
      tick();
      total++;
      if ({mem_addr, cpu_ack} !== {21'h1FFFFF, 1'b0}) begin
         bad++;
         $display("FAIL cpu_read_t2: got addr=%0h ack=%0b want 1fffff 0", mem_addr, cpu_ack);
      end
      tick();
      total++;
      if ({cpu_ack, cpu_rdata} !== {1'b1, 8'hC3}) begin
         bad++;
         $display("FAIL cpu_read_t3: got ack=%0b rdata=%0h want 1 c3", cpu_ack, cpu_rdata);
      end
      cpu_req = 1'b0; mem_rdata = 8'h00;
      tick();
      total++;
      if ({cpu_ack, owner, cpu_rdata} !== {1'b0, 2'd0, 8'hC3}) begin
         bad++;
         $display("FAIL cpu_read_t4: got ack=%0b owner=%0d rdata=%0h want 0 0 c3", cpu_ack, owner, cpu_rdata);
      end
   endtask

   task automatic test_download_stream();
      int waited;
      int low;
      apply_reset();
      tick();
      for (int i = 0; i < 4; i++) begin
         waited = 0;
         while (dl_wait && waited < 20) begin
            tick();
            waited++;
         end
         total++;
         if (waited >= 20) begin
            bad++;
            $display("FAIL dl_wait_timeout: dl_wait still high after %0d cycles want low", waited);
         end
         dl_wr = 1'b1; dl_addr = 21'(i); dl_data = 8'(8'h10 + i);
         #1;
         total++;
         if (dl_wait !== 1'b1) begin
            bad++;
            $display("FAIL dl_wait_same_cycle: got %0b want 1", dl_wait);
         end
         low = 0;
         for (int j = 1; j <= 4; j++) begin
            tick();
            dl_wr = 1'b0; dl_addr = 21'h1ABCDE; dl_data = 8'hEE;
            #1;
            if (mem_we_n === 1'b0) begin
               low++;
               total++;
               if ({mem_addr, mem_wdata, mem_oe, owner} !== {21'(i), 8'(8'h10 + i), 1'b1, 2'd1}) begin
                  bad++;
                  $display("FAIL dl_write_bus: got addr=%0h data=%0h oe=%0b owner=%0d want %0h %0h 1 1",
                           mem_addr, mem_wdata, mem_oe, owner, i, 8'h10 + i);
               end
            end
            total++;
            if (j <= 3 && dl_wait !== 1'b1) begin
               bad++;
               $display("FAIL dl_wait_hold: cycle %0d got %0b want 1", j, dl_wait);
            end else if (j == 4 && {dl_wait, owner} !== {1'b0, 2'd0}) begin
               bad++;
               $display("FAIL dl_wait_release: got wait=%0b owner=%0d want 0 0", dl_wait, owner);
            end
         end
         total++;
         if (low != AC) begin
            bad++;
            $display("FAIL dl_we_width: write %0d got %0d low cycles want %0d", i, low, AC);
         end
      end
   endtask

   task automatic test_collision();
      logic [1:0] prev;
      logic [7:0] seq;
      int nseq, va, ca;
      apply_reset();
      tick();
      dl_wr = 1'b1; dl_addr = 21'h00100; dl_data = 8'h99;
      vid_req = 1'b1; vid_addr = 21'h00200;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 21'h00300;
      prev = 2'd0; seq = 8'd0; nseq = 0; va = 0; ca = 0;
      for (int c = 0; c < 30; c++) begin
         tick();
         dl_wr = 1'b0;
         if (owner != 2'd0 && owner != prev) begin
            seq = {seq[5:0], owner};
            nseq++;
         end
         prev = owner;
         if (vid_ack) begin va++; vid_req = 1'b0; end
         if (cpu_ack) begin ca++; cpu_req = 1'b0; end
      end
      total++;
      if (nseq != 3 || seq[5:0] != 6'b01_10_11) begin
         bad++;
         $display("FAIL collision_order: got %0d grants seq=%b want 3 grants seq=011011", nseq, seq[5:0]);
      end
      total++;
      if (va != 1 || ca != 1) begin
         bad++;
         $display("FAIL collision_acks: got vid=%0d cpu=%0d want 1 1", va, ca);
      end
   endtask

   task automatic test_starvation();
      int n, nv, nc;
      logic exp_cpu;
      apply_reset();
      tick();
      vid_req = 1'b1; vid_addr = 21'h00040;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 21'h00080;
      n = 0; nv = 0; nc = 0;
      for (int c = 0; c < 64; c++) begin
         tick();
         if (vid_ack || cpu_ack) begin
`ifdef SRAM_ARB_FAIR_EN
            exp_cpu = (n % (FMAX + 1)) == FMAX;
`else
            exp_cpu = 1'b0;
`endif
            total++;
            if (cpu_ack !== exp_cpu || vid_ack !== !exp_cpu) begin
               bad++;
               $display("FAIL starve_ack_%0d: got vid=%0b cpu=%0b want cpu=%0b", n, vid_ack, cpu_ack, exp_cpu);
            end
            if (vid_ack) nv++;
            if (cpu_ack) nc++;
            n++;
         end
      end
      total++;
`ifdef SRAM_ARB_FAIR_EN
      if (nc < 2 || n < 12) begin
         bad++;
         $display("FAIL starve_count: got cpu=%0d total=%0d want cpu>=2 total>=12", nc, n);
      end
`else
      if (nc != 0 || nv < 12) begin
         bad++;
         $display("FAIL starve_count: got cpu=%0d vid=%0d want cpu=0 vid>=12", nc, nv);
      end
`endif
      vid_req = 1'b0; cpu_req = 1'b0;
   endtask

   task automatic test_boundary_ac1();
      apply_reset();
      tick();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 21'd0; cpu_wdata = 8'hA5;
      tick();
      total++;
      if ({b_owner, b_mem_we_n, b_mem_oe, b_mem_addr, b_cpu_ack} !== {2'd3, 1'b0, 1'b1, 21'd0, 1'b0}) begin
         bad++;
         $display("FAIL ac1_write_access: got owner=%0d we_n=%0b oe=%0b addr=%0h ack=%0b want 3 0 1 0 0",
                  b_owner, b_mem_we_n, b_mem_oe, b_mem_addr, b_cpu_ack);
      end
      tick();
      total++;
      if ({b_cpu_ack, b_mem_we_n} !== {1'b1, 1'b1}) begin
         bad++;
         $display("FAIL ac1_write_ack: got ack=%0b we_n=%0b want 1 1", b_cpu_ack, b_mem_we_n);
      end
      cpu_req = 1'b0;
      tick();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 21'd0; mem_rdata = 8'h11;
      tick();
      total++;
      if ({b_owner, b_mem_we_n, b_cpu_ack} !== {2'd3, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL ac1_read_access: got owner=%0d we_n=%0b ack=%0b want 3 1 0", b_owner, b_mem_we_n, b_cpu_ack);
      end
      mem_rdata = 8'h77;
      tick();
      total++;
      if ({b_cpu_ack, b_cpu_rdata} !== {1'b1, 8'h77}) begin
         bad++;
         $display("FAIL ac1_read_ack: got ack=%0b rdata=%0h want 1 77", b_cpu_ack, b_cpu_rdata);
      end
      cpu_req = 1'b0; mem_rdata = 8'hEE;
      tick();
      total++;
      if ({b_cpu_ack, b_owner, b_cpu_rdata} !== {1'b0, 2'd0, 8'h77}) begin
         bad++;
         $display("FAIL ac1_read_hold: got ack=%0b owner=%0d rdata=%0h want 0 0 77", b_cpu_ack, b_owner, b_cpu_rdata);
      end
   endtask

   // Reference model: each access is a transaction that starts at the cycle
   // it is granted; expected pins follow from its age k = cycle - start.
   task automatic test_random();
      int          m_start, m_free, k, m_fair;
      logic        m_pend, m_we, done_dl, chk;
      logic [1:0]  m_own;
      logic [20:0] m_dla, m_addr;
      logic [7:0]  m_dld, m_wdata, m_rd, e_vdata, e_cdata;
      logic [1:0]  e_owner;
      logic        e_vack, e_cack, e_wen, e_oe, e_wait;
      apply_reset();
      m_start = -100; m_free = 0; m_fair = 0;
      m_pend = 1'b0; m_we = 1'b0; m_own = 2'd0;
      m_dla = '0; m_dld = '0; m_addr = '0; m_wdata = '0; m_rd = '0;
      e_vdata = '0; e_cdata = '0;
      for (int c = 0; c < 2500; c++) begin
         if (vid_req && vid_ack) vid_req = 1'b0;
         else if (!vid_req && $urandom_range(3) == 0) begin
            vid_req = 1'b1; vid_addr = 21'($urandom);
         end
         if (cpu_req && cpu_ack) cpu_req = 1'b0;
         else if (!cpu_req && $urandom_range(3) == 0) begin
            cpu_req = 1'b1; cpu_we = 1'($urandom); cpu_addr = 21'($urandom); cpu_wdata = 8'($urandom);
         end
         if (dl_wr) dl_wr = 1'b0;
         else if (!dl_wait && $urandom_range(7) == 0) begin
            dl_wr = 1'b1; dl_addr = 21'($urandom); dl_data = 8'($urandom);
         end
         mem_rdata = 8'($urandom);
         #1;
         k = c - m_start;
         e_owner = 2'd0; e_vack = 1'b0; e_cack = 1'b0; e_wen = 1'b1; e_oe = 1'b0; chk = 1'b0;
         if (k >= 1 && k <= AC) begin
            e_owner = m_own; e_wen = !m_we; e_oe = m_we; chk = 1'b1;
         end else if (k == AC + 1) begin
            e_owner = m_own; chk = 1'b1;
            if (m_own == 2'd2) begin e_vack = 1'b1; e_vdata = m_rd; end
            if (m_own == 2'd3) begin e_cack = 1'b1; if (!m_we) e_cdata = m_rd; end
         end
         e_wait = m_pend | dl_wr;
         total++;
         if ({owner, vid_ack, cpu_ack, mem_we_n, mem_oe, dl_wait} !== {e_owner, e_vack, e_cack, e_wen, e_oe, e_wait}) begin
            bad++;
            $display("FAIL rand_ctrl c=%0d: got own=%0d vack=%0b cack=%0b we_n=%0b oe=%0b wait=%0b want %0d %0b %0b %0b %0b %0b",
                     c, owner, vid_ack, cpu_ack, mem_we_n, mem_oe, dl_wait, e_owner, e_vack, e_cack, e_wen, e_oe, e_wait);
         end
         total++;
         if (vid_data !== e_vdata || cpu_rdata !== e_cdata) begin
            bad++;
            $display("FAIL rand_data c=%0d: got vid=%0h cpu=%0h want %0h %0h", c, vid_data, cpu_rdata, e_vdata, e_cdata);
         end
         if (chk) begin
            total++;
            if (mem_addr !== m_addr || (m_we && mem_wdata !== m_wdata)) begin
               bad++;
               $display("FAIL rand_bus c=%0d: got addr=%0h wdata=%0h want %0h %0h", c, mem_addr, mem_wdata, m_addr, m_wdata);
            end
         end
         if (k == AC) m_rd = mem_rdata;
         done_dl = (k == AC + 1) && (m_own == 2'd1);
         if (c >= m_free) begin
            if (m_pend || dl_wr) begin
               m_own = 2'd1; m_we = 1'b1;
               m_addr = m_pend ? m_dla : dl_addr; m_wdata = m_pend ? m_dld : dl_data;
`ifdef SRAM_ARB_FAIR_EN
            end else if (cpu_req && (m_fair >= FMAX || !vid_req)) begin
`else
            end else if (cpu_req && !vid_req) begin
`endif
               m_own = 2'd3; m_we = cpu_we; m_addr = cpu_addr; m_wdata = cpu_wdata;
            end else if (vid_req) begin
               m_own = 2'd2; m_we = 1'b0; m_addr = vid_addr;
            end else begin
               m_own = 2'd0;
            end
            if (m_own != 2'd0) begin
               m_start = c; m_free = c + AC + 2;
`ifdef SRAM_ARB_FAIR_EN
               if (m_own == 2'd3) m_fair = 0;
               if (m_own == 2'd2 && cpu_req) m_fair++;
`endif
            end
         end
`ifdef SRAM_ARB_FAIR_EN
         if (!cpu_req) m_fair = 0;
`endif
         if (dl_wr && !m_pend) begin
            m_pend = 1'b1; m_dla = dl_addr; m_dld = dl_data;
         end
         if (done_dl) m_pend = 1'b0;
         tick();
      end
      vid_req = 1'b0; cpu_req = 1'b0; dl_wr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_cpu_read();
      test_download_stream();
      test_collision();
      test_starvation();
      test_boundary_ac1();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
